// File: rtl/pmod_stand_spi_solo_pkg.sv
// ---------------------------------------------------------------------------
// pmod_stand_spi_solo_pkg
// Shared definitions for the PmodCLS SPI path: ASCII command constants, the
// screen-sequencer state type, command lengths and the byte-selection helper
// that maps a sequencer position to the byte placed on the SPI byte stream.
// ---------------------------------------------------------------------------
package pmod_stand_spi_solo_pkg;

   localparam logic [7:0] ASCII_ESC      = 8'h1B;
   localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
   localparam logic [7:0] ASCII_ZERO     = 8'h30;
   localparam logic [7:0] ASCII_SEMI     = 8'h3B;
   localparam logic [7:0] ASCII_CLEAR    = 8'h6A;
   localparam logic [7:0] ASCII_CURSOR   = 8'h48;

   localparam int CLS_CLR_LEN = 3;
   localparam int CLS_POS_LEN = 6;

   typedef enum logic [2:0] {
      CLS_IDLE,
      CLS_CLR,
      CLS_POS,
      CLS_DAT,
      CLS_DONE
   } t_cls_seq_state;

   // Byte for (state, row, index); row_char is the shadow character already
   // selected for (row, index) and is only used while sending row text.
   function automatic logic [7:0] cls_seq_byte(input t_cls_seq_state st,
                                               input logic [3:0]     row,
                                               input logic [5:0]     idx,
                                               input logic [7:0]     row_char);
      logic [7:0] b;
      b = 8'h00;
      case (st)
         CLS_CLR: begin
            case (idx)
               6'd0:    b = ASCII_ESC;
               6'd1:    b = ASCII_LBRACKET;
               default: b = ASCII_CLEAR;
            endcase
         end
         CLS_POS: begin
            case (idx)
               6'd0:    b = ASCII_ESC;
               6'd1:    b = ASCII_LBRACKET;
               6'd2:    b = ASCII_ZERO + {4'h0, row};
               6'd3:    b = ASCII_SEMI;
               6'd4:    b = ASCII_ZERO;
               default: b = ASCII_CURSOR;
            endcase
         end
         CLS_DAT: b = row_char;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/pmod_cls_screen_sequencer.sv
// ---------------------------------------------------------------------------
// pmod_cls_screen_sequencer
// Streams a PmodCLS screen update as valid/ready bytes with transaction
// framing: optional clear-display, then per selected row a cursor command
// (ESC[r;0H) followed by the row's LINE_CHARS characters.
// Ports:
//   i_clk_20mhz, i_rst_20mhz    clock, async active-high reset
//   i_update_req                start request (taken only when idle)
//   i_clear_first, i_row_mask,
//   i_lines                     captured with the request
//   o_busy, o_done              sequence status / completion pulse
//   o_tx_byte, o_tx_valid,
//   o_tx_last, i_tx_ready       byte stream to the SPI driver
// ---------------------------------------------------------------------------
module pmod_cls_screen_sequencer
   import pmod_stand_spi_solo_pkg::*;
#(
   parameter int NUM_ROWS   = 2,
   parameter int LINE_CHARS = 16
) (
   input  logic                           i_clk_20mhz,
   input  logic                           i_rst_20mhz,
   input  logic                           i_update_req,
   input  logic                           i_clear_first,
   input  logic [NUM_ROWS-1:0]            i_row_mask,
   input  logic [NUM_ROWS*LINE_CHARS*8-1:0] i_lines,
   output logic                           o_busy,
   output logic                           o_done,
   output logic [7:0]                     o_tx_byte,
   output logic                           o_tx_valid,
   input  logic                           i_tx_ready,
   output logic                           o_tx_last
);

   localparam int IDX_W = $clog2((LINE_CHARS > 6) ? LINE_CHARS : 6);
   localparam int RW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(CLS_CLR_LEN - 1);
   localparam logic [IDX_W-1:0] POS_LAST = IDX_W'(CLS_POS_LEN - 1);
   localparam logic [IDX_W-1:0] DAT_LAST = IDX_W'(LINE_CHARS - 1);

   t_cls_seq_state       state, state_nxt;
   logic [IDX_W-1:0]     idx;
   logic [RW-1:0]        row;
   logic [NUM_ROWS-1:0]  rem_mask;
   logic [7:0]           sh_chars [NUM_ROWS][LINE_CHARS];

   logic                 slot_free, load, seg_end, capture;
   logic [RW:0]          req_pick, rem_pick;
   logic [7:0]           tx_byte_nxt;

   // {found, row} of the lowest set bit; lets the scan skip unselected rows
   // without spending cycles on them.
   function automatic logic [RW:0] lowest_set(input logic [NUM_ROWS-1:0] m);
      logic [RW:0] r;
      r = '0;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (m[i]) r = {1'b1, RW'(i)};
      end
      return r;
   endfunction

   assign req_pick    = lowest_set(i_row_mask);
   assign rem_pick    = lowest_set(rem_mask);
   // Output register can take a new byte when empty or being drained now.
   assign slot_free   = !o_tx_valid || i_tx_ready;
   assign tx_byte_nxt = cls_seq_byte(state, 4'(row), 6'(idx), sh_chars[row][idx]);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      seg_end   = 1'b0;
      capture   = 1'b0;
      case (state)
         CLS_IDLE: begin
            // o_done marks the last busy cycle; a request then is ignored.
            if (i_update_req && !o_done) begin
               capture = 1'b1;
               if (i_clear_first)    state_nxt = CLS_CLR;
               else if (req_pick[RW]) state_nxt = CLS_POS;
               else                  state_nxt = CLS_DONE;
            end
         end
         CLS_CLR: begin
            if (slot_free) begin
               load = 1'b1;
               if (idx == CLR_LAST) begin
                  seg_end   = 1'b1;
                  state_nxt = rem_pick[RW] ? CLS_POS : CLS_DONE;
               end
            end
         end
         CLS_POS: begin
            if (slot_free) begin
               load = 1'b1;
               if (idx == POS_LAST) begin
                  seg_end   = 1'b1;
                  state_nxt = CLS_DAT;
               end
            end
         end
         CLS_DAT: begin
            if (slot_free) begin
               load = 1'b1;
               if (idx == DAT_LAST) begin
                  seg_end   = 1'b1;
                  state_nxt = rem_pick[RW] ? CLS_POS : CLS_DONE;
               end
            end
         end
         CLS_DONE: begin
            if (slot_free) state_nxt = CLS_IDLE;
         end
         default: state_nxt = CLS_IDLE;
      endcase
   end

   always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
      if (i_rst_20mhz) begin
         state      <= CLS_IDLE;
         idx        <= '0;
         row        <= '0;
         rem_mask   <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_tx_byte  <= 8'h00;
         o_tx_valid <= 1'b0;
         o_tx_last  <= 1'b0;
         for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < LINE_CHARS; c++)
               sh_chars[r][c] <= 8'h00;
      end else begin
         state <= state_nxt;

         if (state_nxt != state) idx <= '0;
         else if (load)          idx <= idx + 1'b1;

         if (capture) begin
            for (int r = 0; r < NUM_ROWS; r++)
               for (int c = 0; c < LINE_CHARS; c++)
                  sh_chars[r][c] <= i_lines[((NUM_ROWS-1-r)*LINE_CHARS + (LINE_CHARS-1-c))*8 +: 8];
            if (i_clear_first) begin
               rem_mask <= i_row_mask;
            end else begin
               row      <= req_pick[RW-1:0];
               rem_mask <= i_row_mask & ~(NUM_ROWS'(1) << req_pick[RW-1:0]);
            end
         end else if (load && seg_end && (state != CLS_POS) && rem_pick[RW]) begin
            // Leaving CLR or a row's text: claim the next selected row.
            row      <= rem_pick[RW-1:0];
            rem_mask <= rem_mask & ~(NUM_ROWS'(1) << rem_pick[RW-1:0]);
         end

         if (load) begin
            o_tx_valid <= 1'b1;
            o_tx_byte  <= tx_byte_nxt;
            o_tx_last  <= seg_end;
         end else if (state == CLS_DONE && slot_free) begin
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
            o_done     <= 1'b1;
         end

         if (state == CLS_IDLE) begin
            o_done <= 1'b0;
            o_busy <= capture;
         end
      end
   end

endmodule

// File: tb/tb_pmod_cls_screen_sequencer.sv
module tb_pmod_cls_screen_sequencer;

   localparam int NR = 2;
   localparam int LC = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_update_req, i_clear_first;
   logic [NR-1:0]     i_row_mask;
   logic [NR*LC*8-1:0] i_lines;
   logic              o_busy, o_done, o_tx_valid, o_tx_last;
   logic [7:0]        o_tx_byte;
   logic              i_tx_ready = 1'b1;

   bit   rand_mode   = 1'b0;
   bit   ready_fixed = 1'b1;
   bit   model_on    = 1'b0;
   int   n_checks    = 0;
   int   n_fail      = 0;
   int   cyc         = 0;
   int   req_cyc, done_cyc;
   int   xfer_cnt    = 0;
   int   last_cnt    = 0;
   int   done_cnt    = 0;
   logic [8:0] exp_q [$];

   bit         stall_prev = 1'b0;
   logic [7:0] prev_byte;
   logic       prev_last;

   pmod_cls_screen_sequencer #(.NUM_ROWS(NR), .LINE_CHARS(LC)) dut (
      .i_clk_20mhz   (clk),
      .i_rst_20mhz   (rst),
      .i_update_req  (i_update_req),
      .i_clear_first (i_clear_first),
      .i_row_mask    (i_row_mask),
      .i_lines       (i_lines),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_tx_byte     (o_tx_byte),
      .o_tx_valid    (o_tx_valid),
      .i_tx_ready    (i_tx_ready),
      .o_tx_last     (o_tx_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      i_tx_ready = rand_mode ? ($urandom_range(0, 99) < 30) : ready_fixed;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected stream straight from the protocol description.
   task automatic build_model(input bit clr, input logic [NR-1:0] mask, input logic [NR*LC*8-1:0] lines);
      exp_q.delete();
      if (clr) begin
         exp_q.push_back({1'b0, 8'h1B});
         exp_q.push_back({1'b0, 8'h5B});
         exp_q.push_back({1'b1, 8'h6A});
      end
      for (int r = 0; r < NR; r++) begin
         if (mask[r]) begin
            exp_q.push_back({1'b0, 8'h1B});
            exp_q.push_back({1'b0, 8'h5B});
            exp_q.push_back({1'b0, 8'h30 + 8'(r)});
            exp_q.push_back({1'b0, 8'h3B});
            exp_q.push_back({1'b0, 8'h30});
            exp_q.push_back({1'b1, 8'h48});
            for (int c = 0; c < LC; c++)
               exp_q.push_back({(c == LC - 1), lines[(NR*LC - 1 - (r*LC + c))*8 +: 8]});
         end
      end
   endtask

   task automatic start_req(input bit clr, input logic [NR-1:0] mask, input logic [NR*LC*8-1:0] lines);
      i_clear_first = clr;
      i_row_mask    = mask;
      i_lines       = lines;
      i_update_req  = 1'b1;
      build_model(clr, mask, lines);
      model_on = 1'b1;
      @(posedge clk); #1;
      req_cyc      = cyc;
      i_update_req = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, input string name);
      int start;
      start = done_cnt;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk); #1;
         if (done_cnt != start) break;
      end
      chk(name, done_cnt - start, 1);
   endtask

   // Per-cycle compare against the model queue, plus handshake rules.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", o_tx_valid, 1);
            chk("hold_byte", o_tx_byte, prev_byte);
            chk("hold_last", o_tx_last, prev_last);
         end
         if (o_tx_valid && i_tx_ready) begin
            if (model_on) begin
               if (exp_q.size() == 0) chk("extra_byte", {o_tx_last, o_tx_byte}, 9'h1FF);
               else chk("stream_byte", {o_tx_last, o_tx_byte}, exp_q.pop_front());
            end
            xfer_cnt++;
            if (o_tx_last) last_cnt++;
         end
         stall_prev = o_tx_valid && !i_tx_ready;
         prev_byte  = o_tx_byte;
         prev_last  = o_tx_last;
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (model_on) begin
               chk("done_queue_empty", exp_q.size(), 0);
               chk("done_valid_low", o_tx_valid, 0);
               chk("done_busy_high", o_busy, 1);
            end
         end
      end
   end

   logic [NR*LC*8-1:0] lines_a, lines_b;
   int x0, l0, d0;

   initial begin
      lines_a = {"Hello World 0123", "ACL TESTER  V2.0"};
      lines_b = {"ZZZZZZZZZZZZZZZZ", "yyyyyyyyyyyyyyyy"};
      rst = 1'b1;
      i_update_req = 1'b0; i_clear_first = 1'b0; i_row_mask = '0; i_lines = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_valid", o_tx_valid, 0);
      chk("rst_last", o_tx_last, 0);
      chk("rst_byte", o_tx_byte, 8'h00);
      rst = 1'b0;
      @(posedge clk); #1;

      // Full update with clear, continuous ready
      x0 = xfer_cnt; l0 = last_cnt;
      start_req(1'b1, 2'b11, lines_a);
      chk("t1_model_size", exp_q.size(), 47);
      chk("t1_model_clr_last", exp_q[2], {1'b1, 8'h6A});
      chk("t1_model_first_char", exp_q[9], {1'b0, 8'h48});
      chk("t1_model_row0_end", exp_q[24], {1'b1, 8'h33});
      chk("t1_model_row1_digit", exp_q[27], {1'b0, 8'h31});
      chk("t1_busy_after_capture", o_busy, 1);
      chk("t1_no_valid_yet", o_tx_valid, 0);
      @(posedge clk); #1;
      chk("t1_first_valid", o_tx_valid, 1);
      chk("t1_first_byte", o_tx_byte, 8'h1B);
      wait_done(200, "t1_done_seen");
      chk("t1_latency", done_cyc - req_cyc, 48);
      chk("t1_bytes", xfer_cnt - x0, 47);
      chk("t1_lasts", last_cnt - l0, 5);
      @(posedge clk); #1;
      chk("t1_busy_drop", o_busy, 0);
      chk("t1_done_pulse", o_done, 0);

      // Row 1 only, no clear
      x0 = xfer_cnt;
      start_req(1'b0, 2'b10, lines_a);
      chk("t2_model_size", exp_q.size(), 22);
      chk("t2_model_digit", exp_q[2], {1'b0, 8'h31});
      wait_done(200, "t2_done_seen");
      chk("t2_latency", done_cyc - req_cyc, 23);
      chk("t2_bytes", xfer_cnt - x0, 22);
      @(posedge clk); #1;

      // Empty mask, no clear
      x0 = xfer_cnt;
      start_req(1'b0, 2'b00, lines_a);
      wait_done(20, "t3_done_seen");
      chk("t3_latency", done_cyc - req_cyc, 1);
      chk("t3_bytes", xfer_cnt - x0, 0);
      @(posedge clk); #1;

      // Random backpressure
      rand_mode = 1'b1;
      x0 = xfer_cnt;
      start_req(1'b1, 2'b11, lines_a);
      wait_done(2000, "t4_done_seen");
      chk("t4_bytes", xfer_cnt - x0, 47);
      @(posedge clk); #1;

      // Re-request and input changes while busy
      x0 = xfer_cnt;
      start_req(1'b1, 2'b11, lines_a);
      repeat (5) @(posedge clk);
      #1;
      i_lines = lines_b; i_row_mask = 2'b01; i_clear_first = 1'b0; i_update_req = 1'b1;
      @(posedge clk); #1;
      i_update_req = 1'b0;
      wait_done(2000, "t5_done_seen");
      chk("t5_bytes", xfer_cnt - x0, 47);
      d0 = done_cnt;
      repeat (4) @(posedge clk);
      #1;
      chk("t5_no_second_done", done_cnt, d0);
      chk("t5_idle_busy", o_busy, 0);
      rand_mode = 1'b0;

      // Reset mid-sequence
      x0 = xfer_cnt;
      start_req(1'b1, 2'b11, lines_a);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (xfer_cnt - x0 >= 10) break;
      end
      chk("t6_reached_byte10", xfer_cnt - x0, 10);
      d0 = done_cnt;
      rst = 1'b1;
      model_on = 1'b0;
      exp_q.delete();
      #1;
      chk("t6_rst_valid", o_tx_valid, 0);
      chk("t6_rst_busy", o_busy, 0);
      chk("t6_rst_byte", o_tx_byte, 8'h00);
      chk("t6_rst_last", o_tx_last, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("t6_no_done", done_cnt, d0);
      chk("t6_idle_after_rst", o_busy, 0);
      x0 = xfer_cnt;
      start_req(1'b1, 2'b11, lines_a);
      @(posedge clk); #1;
      chk("t6_restart_byte", o_tx_byte, 8'h1B);
      wait_done(200, "t6_done_seen");
      chk("t6_bytes", xfer_cnt - x0, 47);
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
